// File: rtl/mem_ctrl.sv
// Byte-serialising controller that shares one byte-wide RAM between
// instruction fetch and load/store. Loads/fetches read N bytes little-endian,
// stores write N bytes; each completed access ends with a one-cycle done pulse.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  // Load/store port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  // Status
  output logic              busy,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  localparam logic OwnerIf  = 1'b0;
  localparam logic OwnerMem = 1'b1;

  state_e            state_q, state_d;
  // Step counter: in READ it runs 0..N because the last byte arrives one
  // cycle after its address, so it needs one more bit than a byte index.
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_n_q, len_n_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  logic [2:0]        mem_len_n;
  logic [2:0]        cnt_next;
  logic [1:0]        cap_idx;
  logic [1:0]        wr_idx;
  logic [ADDR_W-1:0] addr_next;

  // Decode requested length; 10 is treated as a full word.
  always_comb begin
    unique case (mem_len)
      2'b00:   mem_len_n = 3'd1;
      2'b01:   mem_len_n = 3'd2;
      default: mem_len_n = 3'd4;
    endcase
  end

  // Helper values derived from the step counter.
  always_comb begin
    cnt_next  = cnt_q + 3'd1;
    cap_idx   = cnt_q[1:0] - 2'd1;
    wr_idx    = cnt_q[1:0] + 2'd1;
    addr_next = base_q + ADDR_W'(cnt_next);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_n_d     = len_n_q;
    owner_d     = owner_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_dout_d  = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          owner_d    = OwnerMem;
          base_d     = mem_addr;
          len_n_d    = mem_len_n;
          wdata_d    = mem_wdata;
          rbuf_d     = 32'h0;
          cnt_d      = 3'd0;
          ram_addr_d = mem_addr;
          if (mem_we) begin
            state_d    = StWrite;
            ram_we_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = StRead;
          end
        end else if (if_req && !if_flush) begin
          owner_d    = OwnerIf;
          base_d     = if_addr;
          len_n_d    = 3'd4;
          rbuf_d     = 32'h0;
          cnt_d      = 3'd0;
          ram_addr_d = if_addr;
          state_d    = StRead;
        end
      end

      StRead: begin
        if (owner_q == OwnerIf && if_flush) begin
          // Abort the fetch; any byte still in flight is simply not captured.
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            rbuf_d[8*cap_idx +: 8] = ram_din;
          end
          if (cnt_q == len_n_q) begin
            state_d = StDone;
            cnt_d   = 3'd0;
            if (owner_q == OwnerIf) begin
              if_data_d = rbuf_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = rbuf_d;
              mem_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_next;
            if (cnt_next < len_n_q) begin
              ram_addr_d = addr_next;
            end
          end
        end
      end

      StWrite: begin
        if (cnt_next < len_n_q) begin
          cnt_d      = cnt_next;
          ram_addr_d = addr_next;
          ram_we_d   = 1'b1;
          ram_dout_d = wdata_q[8*wr_idx +: 8];
        end else begin
          state_d    = StDone;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_n_q     <= 3'd4;
      owner_q     <= OwnerIf;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      rbuf_q      <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_n_q     <= len_n_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  // Output mapping.
  always_comb begin
    if_done   = if_done_q;
    if_data   = if_data_q;
    mem_done  = mem_done_q;
    mem_rdata = mem_rdata_q;
    busy      = (state_q != StIdle);
    ram_addr  = ram_addr_q;
    ram_we    = ram_we_q;
    ram_dout  = ram_dout_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_done;
  logic [31:0]   if_data;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_len;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  // Backdoor preload port into the RAM model.
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  logic [7:0]    ram_mem [0:(1<<AW)-1];

  int n_checks;
  int n_fail;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on we, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (pl_en) ram_mem[pl_addr] <= pl_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_dout;
    ram_din <= ram_mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start of a cycle: just after the active edge, where inputs are driven.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sampling point for outputs.
  task automatic look();
    @(negedge clk);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    next_cyc();
    pl_en   = 1'b0;
  endtask

  function automatic logic [31:0] peek_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {ram_mem[a+3], ram_mem[a+2], ram_mem[a+1], ram_mem[a]};
    return w;
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_len   = 2'b00;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = 8'h00;

    // Reset state
    repeat (3) next_cyc();
    look();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_if_done", {31'd0, if_done}, 32'd0);
    check_eq("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst_if_data", if_data, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata, 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    next_cyc();
    rst = 1'b0;

    // IF word fetch at 0x100
    poke(17'h00100, 8'h13);
    poke(17'h00101, 8'h00);
    poke(17'h00102, 8'h50);
    poke(17'h00103, 8'h00);
    next_cyc();
    if_req  = 1'b1;
    if_addr = 17'h00100;
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      look();
      check_eq("fetch_busy", {31'd0, busy}, 32'd1);
      if (k <= 4) begin
        check_eq("fetch_addr", 32'(ram_addr), 32'h100 + 32'(k - 1));
        check_eq("fetch_we", {31'd0, ram_we}, 32'd0);
      end
      check_eq("fetch_done", {31'd0, if_done}, (k == 6) ? 32'd1 : 32'd0);
    end
    check_eq("fetch_data", if_data, 32'h00500013);
    next_cyc();
    if_req = 1'b0;
    look();
    check_eq("fetch_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("fetch_done_pulse", {31'd0, if_done}, 32'd0);

    // Word store 0xDEADBEEF at 0x200
    next_cyc();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_len   = 2'b11;
    mem_addr  = 17'h00200;
    mem_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      next_cyc();
      look();
      if (k <= 4) begin
        check_eq("st_we", {31'd0, ram_we}, 32'd1);
        check_eq("st_addr", 32'(ram_addr), 32'h200 + 32'(k - 1));
      end
      check_eq("st_done", {31'd0, mem_done}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 1) check_eq("st_b0", {24'd0, ram_dout}, 32'hEF);
      if (k == 2) check_eq("st_b1", {24'd0, ram_dout}, 32'hBE);
      if (k == 3) check_eq("st_b2", {24'd0, ram_dout}, 32'hAD);
      if (k == 4) check_eq("st_b3", {24'd0, ram_dout}, 32'hDE);
      if (k == 5) check_eq("st_we_off", {31'd0, ram_we}, 32'd0);
    end
    next_cyc();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    look();
    check_eq("st_ram", peek_word(17'h00200), 32'hDEADBEEF);

    // Half load across the address wrap
    poke(17'h1FFFF, 8'h34);
    poke(17'h00000, 8'h12);
    next_cyc();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'b01;
    mem_addr = 17'h1FFFF;
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      look();
      if (k == 1) check_eq("lh_addr0", 32'(ram_addr), 32'h1FFFF);
      if (k == 2) check_eq("lh_addr1", 32'(ram_addr), 32'h00000);
      check_eq("lh_done", {31'd0, mem_done}, (k == 4) ? 32'd1 : 32'd0);
    end
    check_eq("lh_data", mem_rdata, 32'h00001234);
    next_cyc();
    mem_req = 1'b0;

    // Simultaneous requests: MEM byte load wins, then IF
    poke(17'h00010, 8'hA5);
    next_cyc();
    if_req   = 1'b1;
    if_addr  = 17'h00100;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'b00;
    mem_addr = 17'h00010;
    next_cyc();
    look();
    check_eq("arb_mem_addr", 32'(ram_addr), 32'h10);
    next_cyc();
    look();
    next_cyc();
    look();
    check_eq("arb_mem_done", {31'd0, mem_done}, 32'd1);
    check_eq("arb_mem_data", mem_rdata, 32'h000000A5);
    check_eq("arb_if_not_done", {31'd0, if_done}, 32'd0);
    next_cyc();
    mem_req = 1'b0;
    look();
    check_eq("arb_idle_gap", {31'd0, busy}, 32'd0);
    next_cyc();
    look();
    check_eq("arb_if_addr", 32'(ram_addr), 32'h100);
    check_eq("arb_if_busy", {31'd0, busy}, 32'd1);
    for (int k = 6; k <= 10; k++) begin
      next_cyc();
      look();
      check_eq("arb_if_done", {31'd0, if_done}, (k == 10) ? 32'd1 : 32'd0);
    end
    check_eq("arb_if_data", if_data, 32'h00500013);
    next_cyc();
    if_req = 1'b0;

    // Flush during a fetch
    poke(17'h00300, 8'hAA);
    poke(17'h00301, 8'hBB);
    poke(17'h00302, 8'hCC);
    poke(17'h00303, 8'hDD);
    next_cyc();
    if_req  = 1'b1;
    if_addr = 17'h00300;
    next_cyc();
    look();
    check_eq("fl_addr", 32'(ram_addr), 32'h300);
    next_cyc();
    look();
    next_cyc();
    if_flush = 1'b1;
    look();
    check_eq("fl_busy_t3", {31'd0, busy}, 32'd1);
    next_cyc();
    if_flush = 1'b0;
    if_req   = 1'b0;
    look();
    check_eq("fl_busy_t4", {31'd0, busy}, 32'd0);
    check_eq("fl_ram_addr", 32'(ram_addr), 32'h0);
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      look();
      check_eq("fl_no_done", {31'd0, if_done}, 32'd0);
    end
    check_eq("fl_data_kept", if_data, 32'h00500013);

    // Reset in the middle of a word store
    next_cyc();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_len   = 2'b11;
    mem_addr  = 17'h00400;
    mem_wdata = 32'h11223344;
    next_cyc();
    look();
    check_eq("rs_we_t1", {31'd0, ram_we}, 32'd1);
    next_cyc();
    rst = 1'b1;
    look();
    check_eq("rs_addr_t2", 32'(ram_addr), 32'h401);
    next_cyc();
    rst = 1'b0;
    look();
    check_eq("rs_busy", {31'd0, busy}, 32'd0);
    check_eq("rs_we", {31'd0, ram_we}, 32'd0);
    check_eq("rs_addr", 32'(ram_addr), 32'h0);
    check_eq("rs_dout", {24'd0, ram_dout}, 32'd0);
    check_eq("rs_done", {31'd0, mem_done}, 32'd0);
    check_eq("rs_if_data", if_data, 32'h0);
    check_eq("rs_mem_rdata", mem_rdata, 32'h0);
    check_eq("rs_partial", peek_word(17'h00400), 32'h00003344);
    next_cyc();
    look();
    check_eq("rs_restart_addr", 32'(ram_addr), 32'h400);
    check_eq("rs_restart_we", {31'd0, ram_we}, 32'd1);
    for (int k = 5; k <= 8; k++) begin
      next_cyc();
      look();
      check_eq("rs_restart_done", {31'd0, mem_done}, (k == 8) ? 32'd1 : 32'd0);
    end
    next_cyc();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    look();
    check_eq("rs_ram_final", peek_word(17'h00400), 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller that shares the byte-wide RAM between instruction fetch (IF) and load/store (MEM), serialising each 8/16/32-bit access into byte cycles. It sits between the IF/MEM pipeline stages and the RAM. Requesters hold a request until a one-cycle done pulse; the stall controller uses `busy` and pending requests to drive the pipeline `stall` vector.

## Interface
Parameters:
- ADDR_W, 17, RAM byte-address width
- Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, held until if_done or if_flush
- if_addr  in  ADDR_W  fetch byte address
- if_flush  in  1  abort pending/active fetch (branch redirect)
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  bytes-1: 00=1, 01=2, 11=4; 10 treated as 4
- mem_addr  in  ADDR_W  load/store byte address
- mem_wdata  in  32  store data, byte 0 = bits 7:0
- mem_done  out  1  one-cycle pulse; mem_rdata valid for loads
- mem_rdata  out  32  load data, zero-extended
- busy  out  1  FSM not in IDLE
- ram_addr  out  ADDR_W  RAM byte address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte, valid the cycle after its address is presented

## Operation
- States: IDLE, READ, WRITE, DONE. Byte counter cnt (0..3), length N (1/2/4), owner flag (IF/MEM), latched base address, write data, shift-in buffer.
- IDLE: mem_req has fixed priority over if_req. On grant latch owner, base, N, wdata; go READ (IF, or MEM with we=0) or WRITE. if_req with if_flush high in the same cycle is not granted.
- READ: cycle k (k=0..N-1) drives ram_addr = base+k (mod 2^ADDR_W), ram_we=0. Byte for address k is captured from ram_din at end of cycle k+1 into bits 8k+7:8k. After capturing byte N-1, enter DONE.
- WRITE: cycle k drives ram_addr = base+k, ram_we=1, ram_dout = wdata[8k+7:8k]. After k=N-1 enter DONE.
- DONE: exactly one cycle; pulse owner's done; ram_we=0; requests ignored; next state IDLE.
- if_data/mem_rdata update only when their done pulses; hold value until next completed access of same owner. Unused upper bytes of mem_rdata = 0.
- if_flush during an IF READ: next state IDLE, no if_done, if_data unchanged, in-flight RAM read discarded. if_flush has no effect on MEM transactions.
- Outside READ/WRITE: ram_addr=0, ram_we=0, ram_dout=0.

## Timing
- Reset (rst high at posedge): state IDLE, cnt=0, owner=IF, if_done=0, mem_done=0, if_data=0, mem_rdata=0, busy=0, ram_addr=0, ram_we=0, ram_dout=0. Reset mid-transaction aborts it; a partly completed store is not rolled back, no done is issued.
- Request sampled high in IDLE cycle t: first address in cycle t+1.
- Read of N bytes: addresses t+1..t+N, done pulse in cycle t+N+2 (IF word: t+6).
- Write of N bytes: writes t+1..t+N, done pulse in cycle t+N+1 (word store: t+5).
- Earliest next grant: IDLE cycle after DONE. A requester still asserting req in that cycle starts a new access.
- busy high from cycle t+1 through DONE cycle inclusive.
- Simultaneous if_req and mem_req in IDLE: MEM served; IF served in IDLE cycle after MEM's DONE if still requested.
- Address base+k wraps modulo 2^ADDR_W (0x1FFFF+1 -> 0x00000).

## Test plan
- IF fetch at 0x00100, RAM holds 13,00,50,00 -> ram_addr 0x100..0x103 in t+1..t+4, if_done at t+6, if_data=0x00500013.
- Store word 0xDEADBEEF at 0x00200, len=11 -> ram_we with bytes EF,BE,AD,DE at 0x200..0x203, mem_done at t+5.
- Load half (len=01) at 0x1FFFF, RAM[0x1FFFF]=0x34, RAM[0]=0x12 -> addresses wrap 0x1FFFF,0x00000, mem_rdata=0x00001234.
- if_req and mem_req (byte load 0x10, data 0xA5) same cycle -> MEM first, mem_rdata=0x000000A5, IF granted the IDLE cycle after mem DONE.
- if_flush at t+3 during fetch -> IDLE at t+4, no if_done, if_data unchanged, busy low.
- rst at t+2 during word store -> all outputs 0 next cycle, no mem_done, new request accepted immediately after.
